// File: rtl/modbus_rsp_parser.sv
// Modbus RTU response parser for function 03 (Read Holding Registers).
// Takes bytes from a UART receiver, delimits frames by bus silence, strobes
// each register word as it arrives, checks CRC-16/MODBUS, and on a good
// frame runs a commit sweep so downstream demuxes latch their staged words.
//
// Handshake: rx_valid is a one-cycle qualifier for rx_byte (there is no
// backpressure; every pulse is either consumed or deliberately ignored).
// rx_error in the same cycle as rx_valid wins: the byte is not consumed.
// data_strb, frame_ok and frame_err are one-cycle pulses; crc_validate is a
// level held for exactly nregs cycles. adr/n_data/data_in hold between
// strobes.
module modbus_rsp_parser #(
    parameter int         MAX_REGS   = 10,
    parameter logic [7:0] FUNC_CODE  = 8'h03,
    parameter int         T35_CYCLES = 15200
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [7:0]  rx_byte,
    input  logic        rx_valid,
    input  logic        rx_error,
    output logic [7:0]  adr,
    output logic [7:0]  n_data,
    output logic [15:0] data_in,
    output logic        data_strb,
    output logic        crc_validate,
    output logic        frame_ok,
    output logic        frame_err,
    output logic        busy,
    output logic [3:0]  dbg_state
);

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_FUNC    = 4'd1,
        S_BCNT    = 4'd2,
        S_DATA_HI = 4'd3,
        S_DATA_LO = 4'd4,
        S_CRC_LO  = 4'd5,
        S_CRC_HI  = 4'd6,
        S_COMMIT  = 4'd7,
        S_DISCARD = 4'd8
    } state_t;

    // Largest byte count field accepted (two bytes per register).
    localparam logic [7:0] MAX_BC = 8'(2 * MAX_REGS);

    // Gap counter width: must hold T35_CYCLES itself as the saturation value.
    localparam int            GW  = $clog2(T35_CYCLES + 1);
    localparam logic [GW-1:0] T35 = GW'(T35_CYCLES);

    state_t        state;
    logic [GW-1:0] gap_cnt;
    logic          bus_idle;
    logic [15:0]   crc_q;
    logic [15:0]   crc_next;
    logic [7:0]    hi_byte;
    logic [6:0]    nregs;
    logic [7:0]    idx;
    logic          bcnt_ok;

    // CRC-16/MODBUS: reflected poly 0xA001, one full byte per call.
    function automatic logic [15:0] crc16_update(input logic [15:0] crc,
                                                 input logic [7:0]  b);
        logic [15:0] c;
        c = crc ^ {8'h00, b};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
        end
        return c;
    endfunction

    assign bus_idle  = (gap_cnt == T35);
    assign busy      = (state != S_IDLE);
    assign dbg_state = state;

    // Running CRC including the byte on the bus this cycle, and the
    // byte-count legality test (even, nonzero, within MAX_REGS).
    always_comb begin
        crc_next = crc16_update(crc_q, rx_byte);
        bcnt_ok  = (rx_byte != 8'h00) && !rx_byte[0] && (rx_byte <= MAX_BC);
    end

    // Silence timer: any line activity restarts it, otherwise it counts up
    // and parks at T35 so bus_idle stays asserted through long idle periods.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            gap_cnt <= '0;
        end else if (rx_valid || rx_error) begin
            gap_cnt <= '0;
        end else if (gap_cnt != T35) begin
            gap_cnt <= gap_cnt + GW'(1);
        end
    end

    // Frame state machine with all outputs registered.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= S_IDLE;
            crc_q        <= 16'hFFFF;
            adr          <= 8'h00;
            n_data       <= 8'h00;
            data_in      <= 16'h0000;
            data_strb    <= 1'b0;
            crc_validate <= 1'b0;
            frame_ok     <= 1'b0;
            frame_err    <= 1'b0;
            hi_byte      <= 8'h00;
            nregs        <= 7'd0;
            idx          <= 8'h00;
        end else begin
            data_strb <= 1'b0;
            frame_ok  <= 1'b0;
            frame_err <= 1'b0;

            case (state)
                S_IDLE: begin
                    // A frame may only start after a full T3.5 silence;
                    // a byte arriving earlier is the tail of something we
                    // did not see the start of.
                    if (rx_valid && !rx_error) begin
                        if (bus_idle) begin
                            adr   <= rx_byte;
                            crc_q <= crc16_update(16'hFFFF, rx_byte);
                            state <= S_FUNC;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= S_DISCARD;
                        end
                    end
                end

                S_COMMIT: begin
                    // Sweep n_data 1..nregs with crc_validate high; line
                    // activity is ignored until the sweep is done.
                    if (n_data == {1'b0, nregs}) begin
                        crc_validate <= 1'b0;
                        frame_ok     <= 1'b1;
                        state        <= S_IDLE;
                    end else begin
                        n_data <= n_data + 8'd1;
                    end
                end

                S_DISCARD: begin
                    if (bus_idle) begin
                        state <= S_IDLE;
                    end
                end

                default: begin
                    // In-frame states: line errors and inter-byte timeouts
                    // take precedence over byte consumption.
                    if (rx_error) begin
                        frame_err <= 1'b1;
                        state     <= S_DISCARD;
                    end else if (bus_idle) begin
                        frame_err <= 1'b1;
                        state     <= S_IDLE;
                    end else if (rx_valid) begin
                        crc_q <= crc_next;
                        case (state)
                            S_FUNC: begin
                                if (rx_byte == FUNC_CODE) begin
                                    state <= S_BCNT;
                                end else begin
                                    frame_err <= 1'b1;
                                    state     <= S_DISCARD;
                                end
                            end
                            S_BCNT: begin
                                if (bcnt_ok) begin
                                    nregs <= rx_byte[7:1];
                                    idx   <= 8'd1;
                                    state <= S_DATA_HI;
                                end else begin
                                    frame_err <= 1'b1;
                                    state     <= S_DISCARD;
                                end
                            end
                            S_DATA_HI: begin
                                hi_byte <= rx_byte;
                                state   <= S_DATA_LO;
                            end
                            S_DATA_LO: begin
                                // Words go out before the CRC is known;
                                // downstream stages them until crc_validate.
                                data_in   <= {hi_byte, rx_byte};
                                n_data    <= idx;
                                data_strb <= 1'b1;
                                if (idx == {1'b0, nregs}) begin
                                    state <= S_CRC_LO;
                                end else begin
                                    idx   <= idx + 8'd1;
                                    state <= S_DATA_HI;
                                end
                            end
                            S_CRC_LO: begin
                                state <= S_CRC_HI;
                            end
                            S_CRC_HI: begin
                                // CRC over data plus its own CRC bytes
                                // leaves zero residue on a good frame.
                                if (crc_next == 16'h0000) begin
                                    crc_validate <= 1'b1;
                                    n_data       <= 8'd1;
                                    state        <= S_COMMIT;
                                end else begin
                                    frame_err <= 1'b1;
                                    state     <= S_DISCARD;
                                end
                            end
                            default: begin
                                state <= S_IDLE;
                            end
                        endcase
                    end
                end
            endcase
        end
    end

endmodule
